// File: rtl/des_bridge_pkg.sv
// Shared types and sizing for the DES byte bridge: pack/unpack FSM state
// encodings, block geometry and a byte-insert helper.
package des_bridge_pkg;

  localparam int BYTES_PER_BLOCK = 8;
  localparam int BLOCK_W         = 64;
  localparam int BYTE_W          = 8;
  localparam int CNT_W           = 3;

  // Counter value of the final byte within a block.
  localparam logic [CNT_W-1:0] LAST_BYTE = 3'd7;

  typedef enum logic [0:0] {
    P_FILL = 1'b0,
    P_HOLD = 1'b1
  } pack_state_t;

  typedef enum logic [0:0] {
    U_IDLE = 1'b0,
    U_SEND = 1'b1
  } unpack_state_t;

  // Place byte b into lane idx of blk; lane 0 is the most significant byte.
  function automatic logic [BLOCK_W-1:0] insert_byte(
    input logic [BLOCK_W-1:0] blk,
    input logic [CNT_W-1:0]   idx,
    input logic [BYTE_W-1:0]  b
  );
    logic [BLOCK_W-1:0] r;
    r = blk;
    for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
      if (idx == CNT_W'(k)) begin
        r[BLOCK_W-1-BYTE_W*k -: BYTE_W] = b;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/des_byte_bridge_if.sv
// Bus bundle between the byte FIFOs, the DES core and the bridge.
// master = bridge side, slave = FIFO/DES-core side.
interface des_byte_bridge_if;
  import des_bridge_pkg::*;

  // receive FIFO side
  logic                rx_fifo_empty;
  logic [BYTE_W-1:0]   rx_read_data;
  logic                rx_read_enable;
  // block towards the DES core
  logic [BLOCK_W-1:0]  blk_data;
  logic                blk_valid;
  logic                blk_ready;
  // result from the DES core
  logic [BLOCK_W-1:0]  res_data;
  logic                res_valid;
  logic                res_ready;
  // transmit FIFO side
  logic                tx_fifo_full;
  logic                tx_write_enable;
  logic [BYTE_W-1:0]   tx_write_data;
  // status
  logic                timeout_err;

  modport master (
    input  rx_fifo_empty, rx_read_data, blk_ready, res_data, res_valid, tx_fifo_full,
    output rx_read_enable, blk_data, blk_valid, res_ready, tx_write_enable, tx_write_data,
           timeout_err
  );

  modport slave (
    output rx_fifo_empty, rx_read_data, blk_ready, res_data, res_valid, tx_fifo_full,
    input  rx_read_enable, blk_data, blk_valid, res_ready, tx_write_enable, tx_write_data,
           timeout_err
  );

endinterface

// File: rtl/des_byte_unpacker.sv
// Unpack path: captures a 64-bit DES result and streams it MSB byte first
// into the transmit FIFO, stalling while the FIFO is full.
module des_byte_unpacker
  import des_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic [BLOCK_W-1:0] res_data_i,
  input  logic               res_valid_i,
  output logic               res_ready_o,
  input  logic               tx_fifo_full_i,
  output logic               tx_write_enable_o,
  output logic [BYTE_W-1:0]  tx_write_data_o
);

  unpack_state_t      ustate_q, ustate_d;
  logic [CNT_W-1:0]   ucnt_q, ucnt_d;
  logic [BLOCK_W-1:0] shift_q, shift_d;
  logic               wr_s;

  assign res_ready_o       = (ustate_q == U_IDLE);
  assign wr_s              = (ustate_q == U_SEND) && !tx_fifo_full_i;
  assign tx_write_enable_o = wr_s;
  assign tx_write_data_o   = shift_q[BLOCK_W-1 -: BYTE_W];

  // Unpack state, byte counter and shift register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ustate_q <= U_IDLE;
      ucnt_q   <= {CNT_W{1'b0}};
      shift_q  <= {BLOCK_W{1'b0}};
    end else begin
      ustate_q <= ustate_d;
      ucnt_q   <= ucnt_d;
      shift_q  <= shift_d;
    end
  end

  // Next-state: accept a result when idle, emit one byte per non-full cycle.
  always_comb begin
    ustate_d = ustate_q;
    ucnt_d   = ucnt_q;
    shift_d  = shift_q;
    case (ustate_q)
      U_IDLE: begin
        if (res_valid_i) begin
          shift_d  = res_data_i;
          ucnt_d   = {CNT_W{1'b0}};
          ustate_d = U_SEND;
        end else begin
          ustate_d = U_IDLE;
        end
      end
      U_SEND: begin
        if (wr_s) begin
          shift_d = {shift_q[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
          ucnt_d  = ucnt_q + 3'd1;
          if (ucnt_q == LAST_BYTE) begin
            ustate_d = U_IDLE;
          end else begin
            ustate_d = U_SEND;
          end
        end else begin
          ustate_d = U_SEND;
        end
      end
      default: begin
        ustate_d = U_IDLE;
        ucnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/des_byte_bridge.sv
// DES byte bridge top: packs receive-FIFO bytes into 64-bit blocks for the
// DES core (pack path lives here) and hands results to des_byte_unpacker.
// Optional feature macro DES_PACK_TIMEOUT_EN: discard a partial block after
// TIMEOUT_CYCLES idle cycles and pulse timeout_err.
module des_byte_bridge
  import des_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
)
(
  input  logic              clk,
  input  logic              n_rst,
  des_byte_bridge_if.master bus
);

  pack_state_t        pstate_q, pstate_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [BLOCK_W-1:0] blk_data_q, blk_data_d;
  logic               blk_valid_q, blk_valid_d;
  logic               pop_s;
  logic               timeout_fire_s;

  // Pop whenever filling and data is present; held off while in reset.
  assign pop_s              = (pstate_q == P_FILL) && !bus.rx_fifo_empty && n_rst;
  assign bus.rx_read_enable = pop_s;
  assign bus.blk_data       = blk_data_q;
  assign bus.blk_valid      = blk_valid_q;

  // Pack state, byte counter and assembled block.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pstate_q    <= P_FILL;
      bcnt_q      <= {CNT_W{1'b0}};
      blk_data_q  <= {BLOCK_W{1'b0}};
      blk_valid_q <= 1'b0;
    end else begin
      pstate_q    <= pstate_d;
      bcnt_q      <= bcnt_d;
      blk_data_q  <= blk_data_d;
      blk_valid_q <= blk_valid_d;
    end
  end

  // Next-state: fill lanes MSB first, then hold the block until accepted.
  always_comb begin
    pstate_d    = pstate_q;
    bcnt_d      = bcnt_q;
    blk_data_d  = blk_data_q;
    blk_valid_d = blk_valid_q;
    case (pstate_q)
      P_FILL: begin
        if (pop_s) begin
          blk_data_d = insert_byte(blk_data_q, bcnt_q, bus.rx_read_data);
          bcnt_d     = bcnt_q + 3'd1;
          if (bcnt_q == LAST_BYTE) begin
            pstate_d    = P_HOLD;
            blk_valid_d = 1'b1;
          end else begin
            pstate_d = P_FILL;
          end
        end else if (timeout_fire_s) begin
          // Stale lanes stay in blk_data_q; they are overwritten from lane 0.
          bcnt_d = {CNT_W{1'b0}};
        end else begin
          bcnt_d = bcnt_q;
        end
      end
      P_HOLD: begin
        if (blk_valid_q && bus.blk_ready) begin
          pstate_d    = P_FILL;
          blk_valid_d = 1'b0;
        end else begin
          pstate_d = P_HOLD;
        end
      end
      default: begin
        pstate_d    = P_FILL;
        bcnt_d      = {CNT_W{1'b0}};
        blk_valid_d = 1'b0;
      end
    endcase
  end

`ifdef DES_PACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            timeout_err_q;

  assign bus.timeout_err = timeout_err_q;

  // Idle counter for a partially filled block, plus the error pulse register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tcnt_q        <= {TO_W{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      tcnt_q        <= tcnt_d;
      timeout_err_q <= timeout_fire_s;
    end
  end

  // Count idle partial-block cycles; fire as the count steps onto
  // TIMEOUT_CYCLES-1 so the pulse lands TIMEOUT_CYCLES cycles after the last pop.
  always_comb begin
    tcnt_d         = tcnt_q;
    timeout_fire_s = 1'b0;
    if (pop_s) begin
      tcnt_d = {TO_W{1'b0}};
    end else if ((pstate_q == P_FILL) && (bcnt_q != {CNT_W{1'b0}})) begin
      if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 2)) begin
        timeout_fire_s = 1'b1;
        tcnt_d         = {TO_W{1'b0}};
      end else begin
        tcnt_d = tcnt_q + TO_W'(1);
      end
    end else begin
      tcnt_d = tcnt_q;
    end
  end
`else
  assign timeout_fire_s  = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  des_byte_unpacker u_unpack (
    .clk               (clk),
    .n_rst             (n_rst),
    .res_data_i        (bus.res_data),
    .res_valid_i       (bus.res_valid),
    .res_ready_o       (bus.res_ready),
    .tx_fifo_full_i    (bus.tx_fifo_full),
    .tx_write_enable_o (bus.tx_write_enable),
    .tx_write_data_o   (bus.tx_write_data)
  );

endmodule

// File: tb/tb_des_byte_bridge.sv
// Self-checking bench for des_byte_bridge: directed scenarios followed by
// random traffic, all checked every cycle against a queue-based model.
module tb_des_byte_bridge;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic n_rst;

  des_byte_bridge_if bif ();

  des_byte_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc = 0, last_pop = 0, pops = 0, bv_cnt = 0, to_cnt = 0, to_cyc = 0;
  int first_wr = 0, last_wr = 0;
  int p0, b0, n;
  logic rdy_v, full_v;
  logic [7:0]  rxq[$];     // bytes waiting in the receive FIFO
  logic [7:0]  cur[$];     // bytes popped into the block being built
  logic [7:0]  txrem[$];   // result bytes still owed to the transmit FIFO
  logic [7:0]  txlog[$];   // bytes actually written by the DUT
  logic [63:0] resq[$];    // results waiting to be offered
  logic [63:0] blocks[$];  // blocks accepted from the DUT (model view)
  logic [7:0]  exp40[8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
  logic [7:0]  exp41[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack8(input logic [7:0] q[$]);
    logic [63:0] r = 64'h0;
    for (int k = 0; k < 8; k++) r = (r << 8) | 64'(q[k]);
    return r;
  endfunction

  // One clock cycle: drive inputs from the model, check outputs, advance model.
  task automatic tick();
    logic exp_rd, exp_bv, exp_rr, exp_we, exp_to;
    logic [63:0] w;
    @(negedge clk);
    bif.rx_fifo_empty = (rxq.size() == 0);
    if (rxq.size() == 0) bif.rx_read_data = 8'h00;
    else                 bif.rx_read_data = rxq[0];
    bif.blk_ready    = rdy_v;
    bif.res_valid    = (resq.size() != 0);
    if (resq.size() == 0) bif.res_data = 64'h0;
    else                  bif.res_data = resq[0];
    bif.tx_fifo_full = full_v;
    #1;
    cyc++;
    exp_to = 1'b0;
`ifdef DES_PACK_TIMEOUT_EN
    if (cur.size() > 0 && cur.size() < 8 && (cyc - last_pop) == TO) begin
      exp_to = 1'b1;
      cur.delete();
    end
`endif
    exp_rd = !bif.rx_fifo_empty && (cur.size() < 8);
    exp_bv = (cur.size() == 8);
    exp_rr = (txrem.size() == 0);
    exp_we = !exp_rr && !full_v;
    chk("timeout_err", bif.timeout_err, exp_to);
    chk("rx_read_enable", bif.rx_read_enable, exp_rd);
    chk("blk_valid", bif.blk_valid, exp_bv);
    if (exp_bv) chk("blk_data", bif.blk_data, pack8(cur));
    chk("res_ready", bif.res_ready, exp_rr);
    chk("tx_write_enable", bif.tx_write_enable, exp_we);
    if (exp_we) chk("tx_write_data", bif.tx_write_data, txrem[0]);
    // observations of the DUT used by directed checks
    if (bif.blk_valid) bv_cnt++;
    if (bif.timeout_err) begin to_cnt++; to_cyc = cyc; end
    if (bif.tx_write_enable) begin
      if (txlog.size() == 0) first_wr = cyc;
      last_wr = cyc;
      txlog.push_back(bif.tx_write_data);
    end
    // model advance
    if (exp_bv && rdy_v) begin blocks.push_back(pack8(cur)); cur.delete(); end
    if (exp_rd) begin cur.push_back(rxq.pop_front()); pops++; last_pop = cyc; end
    if (exp_we) void'(txrem.pop_front());
    if (exp_rr && bif.res_valid) begin
      w = resq.pop_front();
      for (int k = 0; k < 8; k++) txrem.push_back(w[63-8*k -: 8]);
    end
  endtask

  // Assert reset with receive data present, check reset outputs, release.
  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    bif.rx_fifo_empty = 1'b0;
    bif.rx_read_data  = 8'hA5;
    bif.tx_fifo_full  = 1'b0;
    #1;
    chk("rst_rx_read_enable", bif.rx_read_enable, 0);
    chk("rst_blk_valid", bif.blk_valid, 0);
    chk("rst_blk_data", bif.blk_data, 0);
    chk("rst_tx_write_enable", bif.tx_write_enable, 0);
    chk("rst_timeout_err", bif.timeout_err, 0);
    chk("rst_res_ready", bif.res_ready, 1);
    cur.delete();
    txrem.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    bif.rx_fifo_empty = 1'b1;
    bif.res_valid     = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    rdy_v = 1'b0;
    full_v = 1'b0;
    bif.rx_fifo_empty = 1'b1;
    bif.rx_read_data  = 8'h00;
    bif.blk_ready     = 1'b0;
    bif.res_data      = 64'h0;
    bif.res_valid     = 1'b0;
    bif.tx_fifo_full  = 1'b0;
    do_reset();

    // single block, consumer always ready
    rdy_v = 1'b1;
    for (int i = 1; i <= 8; i++) rxq.push_back(8'(i));
    repeat (14) tick();
    chk("req038_pops", pops, 8);
    chk("req038_blocks", blocks.size(), 1);
    chk("req038_block", blocks[0], 64'h0102030405060708);
    chk("req038_valid_cycles", bv_cnt, 1);

    // back-pressure with 16 bytes queued
    rdy_v = 1'b0; p0 = pops; b0 = blocks.size(); bv_cnt = 0;
    for (int i = 0; i < 16; i++) rxq.push_back(8'h11 + 8'(i));
    repeat (28) tick();
    chk("req039_pops_held", pops - p0, 8);
    chk("req039_no_accept", blocks.size(), b0);
    chk("req039_valid_cycles", bv_cnt, 20);
    rdy_v = 1'b1;
    repeat (20) tick();
    chk("req039_pops_all", pops - p0, 16);
    chk("req039_blocks", blocks.size(), b0 + 2);
    chk("req039_block1", blocks[b0], 64'h1112131415161718);
    chk("req039_block2", blocks[b0+1], 64'h191A1B1C1D1E1F20);

    // unpack, FIFO never full
    txlog.delete(); full_v = 1'b0;
    resq.push_back(64'hA1B2C3D4E5F60718);
    repeat (12) tick();
    chk("req040_count", txlog.size(), 8);
    chk("req040_span", last_wr - first_wr, 7);
    for (int k = 0; k < 8; k++) chk("req040_byte", txlog[k], exp40[k]);

    // stall after the third byte
    txlog.delete();
    resq.push_back(64'h1122334455667788);
    n = 0;
    while (txlog.size() < 3 && n < 20) begin tick(); n++; end
    chk("req041_reach3", txlog.size(), 3);
    full_v = 1'b1;
    repeat (5) tick();
    chk("req041_stall", txlog.size(), 3);
    full_v = 1'b0;
    repeat (10) tick();
    chk("req041_count", txlog.size(), 8);
    for (int k = 0; k < 8; k++) chk("req041_byte", txlog[k], exp41[k]);

    // reset mid-block discards the partial bytes
    p0 = pops;
    for (int i = 0; i < 4; i++) rxq.push_back(8'hE0 + 8'(i));
    n = 0;
    while (pops - p0 < 4 && n < 20) begin tick(); n++; end
    chk("req042_pre_pops", pops - p0, 4);
    do_reset();
    b0 = blocks.size(); rdy_v = 1'b1;
    for (int i = 0; i < 8; i++) rxq.push_back(8'h31 + 8'(i));
    repeat (14) tick();
    chk("req042_blocks", blocks.size(), b0 + 1);
    chk("req042_block", blocks[b0], 64'h3132333435363738);

`ifdef DES_PACK_TIMEOUT_EN
    // partial block timeout
    to_cnt = 0;
    for (int i = 0; i < 3; i++) rxq.push_back(8'hC1 + 8'(i));
    repeat (25) tick();
    chk("req043_pulses", to_cnt, 1);
    chk("req043_delay", to_cyc - last_pop, 16);
    b0 = blocks.size();
    for (int i = 0; i < 8; i++) rxq.push_back(8'hD1 + 8'(i));
    repeat (14) tick();
    chk("req043_blocks", blocks.size(), b0 + 1);
    chk("req043_block", blocks[b0], 64'hD1D2D3D4D5D6D7D8);
`endif

    // random traffic on both paths at once
    b0 = blocks.size();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0 && rxq.size() < 20) rxq.push_back(8'($urandom));
      rdy_v  = ($urandom_range(0, 2) != 0);
      full_v = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0 && resq.size() < 3) resq.push_back({$urandom, $urandom});
      tick();
    end
    rdy_v = 1'b1; full_v = 1'b0;
    repeat (60) tick();
    chk("rand_blocks_seen", blocks.size() > b0 + 5, 1);
    chk("rand_results_drained", txrem.size() + resq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_byte_bridge.md
DES_BYTE_BRIDGE -- requirements
Module: des_byte_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, idle cycles before a partial block is discarded (used only with DES_PACK_TIMEOUT_EN).
REQ-002 SHALL have a single clock and an asynchronous, active-low reset: clk  input  1  system clock, all state changes on rising edge.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 rx_fifo_empty  input  1  receive FIFO has no data.
REQ-005 rx_read_data  input  8  receive FIFO head byte, valid while rx_fifo_empty=0.
REQ-006 rx_read_enable  output  1  pops one byte from the receive FIFO.
REQ-007 blk_data  output  64  assembled block to the DES core.
REQ-008 blk_valid  output  1  blk_data is valid.
REQ-009 blk_ready  input  1  DES core accepts blk_data.
REQ-010 res_data  input  64  DES result block.
REQ-011 res_valid  input  1  res_data is valid.
REQ-012 res_ready  output  1  bridge accepts res_data.
REQ-013 tx_fifo_full  input  1  transmit FIFO cannot accept data.
REQ-014 tx_write_enable  output  1  pushes tx_write_data into the transmit FIFO.
REQ-015 tx_write_data  output  8  byte to the transmit FIFO.
REQ-016 timeout_err  output  1  one-cycle pulse when a partial block is discarded.

Function
REQ-017 Pack FSM states SHALL be P_FILL and P_HOLD, with a 3-bit byte counter.
REQ-018 In P_FILL, rx_read_enable SHALL be high exactly when rx_fifo_empty=0; rx_read_data SHALL be sampled in that same cycle.
REQ-019 Byte k (k=0..7, arrival order) SHALL land in blk_data[63-8k -: 8]; the first byte is the MSB.
REQ-020 The cycle the 8th byte is popped, the counter SHALL wrap to 0 and the FSM SHALL go to P_HOLD; blk_valid SHALL rise the next cycle.
REQ-021 In P_HOLD, rx_read_enable SHALL be 0, and blk_data and blk_valid SHALL be held stable until blk_valid and blk_ready are both high; then the FSM SHALL return to P_FILL.
REQ-022 Minimum latency SHALL be 8 pop cycles to blk_valid, plus 1 cycle.
REQ-023 Unpack FSM states SHALL be U_IDLE and U_SEND, with a 3-bit counter and a 64-bit shift register.
REQ-024 res_ready SHALL equal (state==U_IDLE); on res_valid and res_ready, res_data SHALL be captured and the FSM SHALL enter U_SEND.
REQ-025 In U_SEND, tx_write_enable SHALL be high exactly when tx_fifo_full=0, and tx_write_data SHALL be the current MSB byte.
REQ-026 On each write the register SHALL shift left by 8; after the 8th write the FSM SHALL return to U_IDLE.
REQ-027 When tx_fifo_full=1, the FSM SHALL stall with no write and no state change.
REQ-028 Pack and unpack paths SHALL be fully independent; simultaneous events on both paths SHALL each be handled in the same cycle.

Reset
REQ-029 On n_rst=0, the FSMs SHALL go to P_FILL and U_IDLE, and the counters SHALL clear to 0.
REQ-030 On n_rst=0, blk_data and the shift register SHALL clear to 0.
REQ-031 On n_rst=0, rx_read_enable, blk_valid, tx_write_enable and timeout_err SHALL be 0, and res_ready SHALL be 1 after reset release.
REQ-032 Reset mid-block SHALL discard all partial data; already-popped bytes are lost.

Configuration
REQ-033 With DES_PACK_TIMEOUT_EN defined, a counter SHALL count cycles in P_FILL with counter != 0 and no pop; it SHALL clear on any pop.
REQ-034 With DES_PACK_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES-1, the byte counter SHALL clear and timeout_err SHALL pulse for one cycle.
REQ-035 Without DES_PACK_TIMEOUT_EN, timeout_err SHALL be tied to 0, and partial blocks SHALL wait indefinitely.

Structure
REQ-036 Package des_bridge_pkg SHALL hold the pack_state_t and unpack_state_t enums, BYTES_PER_BLOCK=8 and BLOCK_W=64.
REQ-037 The unpack path SHALL be the single sub-module des_byte_unpacker; the pack logic SHALL stay in the top module.

Verification
REQ-038 Push 01..08 with blk_ready=1 -> blk_data=0x0102030405060708, blk_valid high for 1 cycle, 8 pops total.
REQ-039 Hold blk_ready=0 for 20 cycles with 16 bytes queued -> blk_data stays stable, no pops beyond 8; release -> the second block follows.
REQ-040 res_data=0xA1B2C3D4E5F60718 with tx_fifo_full=0 -> bytes A1,B2,...,18 on 8 consecutive cycles, res_ready low during the sends.
REQ-041 Raise tx_fifo_full for 5 cycles after the 3rd byte -> no writes during the stall, 5 remaining bytes resume in order.
REQ-042 Assert n_rst after 4 pops, then push 8 new bytes -> the block contains only the new bytes.
REQ-043 With DES_PACK_TIMEOUT_EN and TIMEOUT_CYCLES=16, push 3 bytes then idle -> timeout_err pulses 16 cycles after the last pop, and the next 8 bytes form a clean block.
